// File: rtl/r16_tf_delay_align.sv
// r16_tf_delay_align: issues twiddle requests and delays 16 lanes by TF_LAT to meet the twiddles.
// Optional R16_ALIGN_ZERO_EN: zero the lanes during bubbles so the multiplier stays quiet.
`ifndef D_width
`define D_width 16
`endif
module r16_tf_delay_align #(
   parameter int TF_LAT = 4,
   parameter int IDX_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_last,
   input  logic [`D_width-1:0] R16_in0,  R16_in1,  R16_in2,  R16_in3,
   input  logic [`D_width-1:0] R16_in4,  R16_in5,  R16_in6,  R16_in7,
   input  logic [`D_width-1:0] R16_in8,  R16_in9,  R16_in10, R16_in11,
   input  logic [`D_width-1:0] R16_in12, R16_in13, R16_in14, R16_in15,
   output logic                tf_req,
   output logic [IDX_W-1:0]    tf_idx,
   output logic [`D_width-1:0] R16_delay_out0,  R16_delay_out1,  R16_delay_out2,  R16_delay_out3,
   output logic [`D_width-1:0] R16_delay_out4,  R16_delay_out5,  R16_delay_out6,  R16_delay_out7,
   output logic [`D_width-1:0] R16_delay_out8,  R16_delay_out9,  R16_delay_out10, R16_delay_out11,
   output logic [`D_width-1:0] R16_delay_out12, R16_delay_out13, R16_delay_out14, R16_delay_out15,
   output logic                out_valid,
   output logic                out_last,
   output logic [IDX_W-1:0]    grp_cnt
);
`ifdef R16_ALIGN_ZERO_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif
   logic [`D_width-1:0] lane_in  [16];
   logic [`D_width-1:0] lane_out [16];
   logic [`D_width-1:0] dl       [TF_LAT][16];
   logic [TF_LAT-1:0]   v_q, l_q;

   assign lane_in = '{R16_in0, R16_in1, R16_in2, R16_in3, R16_in4, R16_in5, R16_in6, R16_in7,
                      R16_in8, R16_in9, R16_in10, R16_in11, R16_in12, R16_in13, R16_in14, R16_in15};

   assign tf_req    = in_valid;
   assign tf_idx    = grp_cnt;
   assign out_valid = v_q[TF_LAT-1];
   assign out_last  = l_q[TF_LAT-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp_cnt <= '0;
         v_q     <= '0;
         l_q     <= '0;
         for (int i = 0; i < TF_LAT; i++)
            for (int k = 0; k < 16; k++)
               dl[i][k] <= '0;
      end else begin
         if (in_valid)
            grp_cnt <= in_last ? '0 : grp_cnt + 1'b1;
         v_q[0] <= in_valid;
         l_q[0] <= in_valid & in_last;
         for (int k = 0; k < 16; k++)
            dl[0][k] <= (ZERO_EN && !in_valid) ? '0 : lane_in[k];
         // shift unconditionally so bubbles keep their exact position
         for (int i = 1; i < TF_LAT; i++) begin
            v_q[i] <= v_q[i-1];
            l_q[i] <= l_q[i-1];
            dl[i]  <= dl[i-1];
         end
      end
   end

   always_comb
      for (int k = 0; k < 16; k++)
         lane_out[k] = (ZERO_EN && !out_valid) ? '0 : dl[TF_LAT-1][k];

   assign R16_delay_out0  = lane_out[0];
   assign R16_delay_out1  = lane_out[1];
   assign R16_delay_out2  = lane_out[2];
   assign R16_delay_out3  = lane_out[3];
   assign R16_delay_out4  = lane_out[4];
   assign R16_delay_out5  = lane_out[5];
   assign R16_delay_out6  = lane_out[6];
   assign R16_delay_out7  = lane_out[7];
   assign R16_delay_out8  = lane_out[8];
   assign R16_delay_out9  = lane_out[9];
   assign R16_delay_out10 = lane_out[10];
   assign R16_delay_out11 = lane_out[11];
   assign R16_delay_out12 = lane_out[12];
   assign R16_delay_out13 = lane_out[13];
   assign R16_delay_out14 = lane_out[14];
   assign R16_delay_out15 = lane_out[15];
endmodule

// File: tb/tb_r16_tf_delay_align.sv
// tb_r16_tf_delay_align: two configurations (4/8 and 2/3) driven in parallel against a cycle-history model.
`ifndef D_width
`define D_width 16
`endif
module tb_r16_tf_delay_align;
   localparam int DW = `D_width;
   localparam int PW = DW * 16;
   localparam int HN = 4096;
`ifdef R16_ALIGN_ZERO_EN
   localparam bit ZE = 1'b1;
`else
   localparam bit ZE = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_last = 1'b0;
   logic [DW-1:0] din [16];
   logic [DW-1:0] oa [16];
   logic [DW-1:0] ob [16];
   logic [PW-1:0] pa, pb;
   logic a_req, a_v, a_l, b_req, b_v, b_l;
   logic [7:0] a_idx, a_grp;
   logic [2:0] b_idx, b_grp;

   bit            hv [HN];
   bit            hl [HN];
   logic [PW-1:0] hd [HN];
   int cyc = 0, rst_cyc = 0, cnt_a = 0, cnt_b = 0;
   int errs = 0, checks = 0;

   always #5 clk = ~clk;

   r16_tf_delay_align #(.TF_LAT(4), .IDX_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .R16_in0(din[0]), .R16_in1(din[1]), .R16_in2(din[2]), .R16_in3(din[3]),
      .R16_in4(din[4]), .R16_in5(din[5]), .R16_in6(din[6]), .R16_in7(din[7]),
      .R16_in8(din[8]), .R16_in9(din[9]), .R16_in10(din[10]), .R16_in11(din[11]),
      .R16_in12(din[12]), .R16_in13(din[13]), .R16_in14(din[14]), .R16_in15(din[15]),
      .tf_req(a_req), .tf_idx(a_idx),
      .R16_delay_out0(oa[0]), .R16_delay_out1(oa[1]), .R16_delay_out2(oa[2]), .R16_delay_out3(oa[3]),
      .R16_delay_out4(oa[4]), .R16_delay_out5(oa[5]), .R16_delay_out6(oa[6]), .R16_delay_out7(oa[7]),
      .R16_delay_out8(oa[8]), .R16_delay_out9(oa[9]), .R16_delay_out10(oa[10]), .R16_delay_out11(oa[11]),
      .R16_delay_out12(oa[12]), .R16_delay_out13(oa[13]), .R16_delay_out14(oa[14]), .R16_delay_out15(oa[15]),
      .out_valid(a_v), .out_last(a_l), .grp_cnt(a_grp));

   r16_tf_delay_align #(.TF_LAT(2), .IDX_W(3)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .R16_in0(din[0]), .R16_in1(din[1]), .R16_in2(din[2]), .R16_in3(din[3]),
      .R16_in4(din[4]), .R16_in5(din[5]), .R16_in6(din[6]), .R16_in7(din[7]),
      .R16_in8(din[8]), .R16_in9(din[9]), .R16_in10(din[10]), .R16_in11(din[11]),
      .R16_in12(din[12]), .R16_in13(din[13]), .R16_in14(din[14]), .R16_in15(din[15]),
      .tf_req(b_req), .tf_idx(b_idx),
      .R16_delay_out0(ob[0]), .R16_delay_out1(ob[1]), .R16_delay_out2(ob[2]), .R16_delay_out3(ob[3]),
      .R16_delay_out4(ob[4]), .R16_delay_out5(ob[5]), .R16_delay_out6(ob[6]), .R16_delay_out7(ob[7]),
      .R16_delay_out8(ob[8]), .R16_delay_out9(ob[9]), .R16_delay_out10(ob[10]), .R16_delay_out11(ob[11]),
      .R16_delay_out12(ob[12]), .R16_delay_out13(ob[13]), .R16_delay_out14(ob[14]), .R16_delay_out15(ob[15]),
      .out_valid(b_v), .out_last(b_l), .grp_cnt(b_grp));

   always_comb
      for (int k = 0; k < 16; k++) begin
         pa[k*DW +: DW] = oa[k];
         pb[k*DW +: DW] = ob[k];
      end

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // expected outputs: the beat entered lat cycles ago, unless a reset has discarded it since
   task automatic check_inst(input string p, input int lat, input logic req, input logic [7:0] idx,
                             input logic [7:0] grp, input int cnt, input logic v, input logic l,
                             input logic [PW-1:0] d);
      int h = cyc - lat;
      bit ev = 1'b0, el = 1'b0;
      logic [PW-1:0] ed = '0;
      if (h >= rst_cyc) begin
         ev = hv[h];
         el = hv[h] & hl[h];
         ed = (ZE && !hv[h]) ? '0 : hd[h];
      end
      check({p, "_tf_req"}, PW'(req), PW'(in_valid));
      check({p, "_tf_idx"}, PW'(idx), PW'(cnt));
      check({p, "_grp_cnt"}, PW'(grp), PW'(cnt));
      check({p, "_out_valid"}, PW'(v), PW'(ev));
      check({p, "_out_last"}, PW'(l), PW'(el));
      check({p, "_data"}, d, ed);
   endtask

   task automatic step(input bit v, input bit l, input bit r, input logic [PW-1:0] d);
      in_valid = v;
      in_last  = l;
      rst      = r;
      for (int k = 0; k < 16; k++) din[k] = d[k*DW +: DW];
      if (r) begin
         rst_cyc = cyc + 1;
         cnt_a = 0;
         cnt_b = 0;
      end
      #1;
      check_inst("a", 4, a_req, a_idx, a_grp, cnt_a, a_v, a_l, pa);
      check_inst("b", 2, b_req, 8'(b_idx), 8'(b_grp), cnt_b, b_v, b_l, pb);
      hv[cyc] = v;
      hl[cyc] = l;
      hd[cyc] = d;
      @(posedge clk);
      if (!r && v) begin
         cnt_a = l ? 0 : (cnt_a + 1) % 256;
         cnt_b = l ? 0 : (cnt_b + 1) % 8;
      end
      #1;
      cyc++;
   endtask

   function automatic logic [PW-1:0] seq(input int b);
      logic [PW-1:0] d;
      for (int k = 0; k < 16; k++) d[k*DW +: DW] = DW'(16 * b + k);
      return d;
   endfunction

   function automatic logic [PW-1:0] rnd();
      logic [PW-1:0] d;
      for (int k = 0; k < 16; k++) d[k*DW +: DW] = DW'($urandom);
      return d;
   endfunction

   initial begin
      bit bub [7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int k = 0; k < 16; k++) din[k] = '0;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      // reset with random data, then with in_valid held high
      for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'b1, rnd());
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b1, rnd());
      // streaming 10 beats, last on beat 9
      for (int b = 0; b < 10; b++) step(1'b1, b == 9, 1'b0, seq(b));
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, rnd());
      // bubbles
      for (int i = 0; i < 7; i++) step(bub[i], 1'b0, 1'b0, rnd());
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, rnd());
      // run counters toward wrap: b wraps at 8; last on idx 7 of b at the end
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, rnd());
      while (cnt_b != 7) step(1'b1, 1'b0, 1'b0, rnd());
      step(1'b1, 1'b1, 1'b0, rnd());
      step(1'b1, 1'b0, 1'b0, rnd());
      // stray last
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, rnd());
      // mid-stream reset with 3 beats in flight
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, rnd());
      step(1'b0, 1'b0, 1'b1, rnd());
      step(1'b1, 1'b0, 1'b0, rnd());
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, rnd());
      // random traffic
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0, rnd());
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, rnd());
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
